// File: rtl/rr_dec_sel.sv
// Round-robin selector over four request lines that feeds a 2-to-4 one-hot decoder (sel/en).
// Latency: one cycle from req sampled high to en=1. Every output is registered.
// Backpressure: a grant is held until done, until the owner drops req, or until MAX_HOLD cycles pass.
//   A one-cycle en=0 gap always follows a release.
//
// Ports:
//   clk, rst_n : rising-edge clock and asynchronous active-low reset
//   req[3:0]   : per-channel request
//   done       : owner releases the current grant (ignored while en=0)
//   sel[1:0]   : granted channel index, the decoder select
//   en         : grant active, the decoder enable
//   timeout    : one-cycle pulse on the first gap cycle after a forced release
//
// HW must satisfy 2^HW > MAX_HOLD. MAX_HOLD=0 disables the hold limit.
module rr_dec_sel #(
  parameter int MAX_HOLD = 16,
  parameter int HW       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic       en,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  // Counter value seen on the last allowed grant cycle. Only used when MAX_HOLD != 0.
  localparam int            HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [HW-1:0] HOLD_LAST   = HOLD_LAST_I[HW-1:0];

  state_t        state;
  logic [1:0]    last;
  logic [HW-1:0] hcnt;
  logic [1:0]    winner;
  logic [1:0]    cand;
  logic          rel_done, rel_drop, rel_hold, release_now;

  // Scan from the farthest candidate (last+4) down to the nearest one (last+1).
  // The nearest requester is written last, so it wins.
  always_comb begin
    winner = last;
    cand   = last;
    for (int i = 4; i >= 1; i--) begin
      cand = last + 2'(i);
      if (req[cand]) winner = cand;
    end
  end

  assign rel_done    = done;
  assign rel_drop    = ~req[sel];
  assign rel_hold    = (MAX_HOLD != 0) && (hcnt == HOLD_LAST);
  assign release_now = rel_done | rel_drop | rel_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= 2'b00;
      en      <= 1'b0;
      timeout <= 1'b0;
      hcnt    <= '0;
      last    <= 2'b11;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            sel   <= winner;
            en    <= 1'b1;
            hcnt  <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            en      <= 1'b0;
            last    <= sel;
            state   <= IDLE;
            // A forced release is flagged only when it is the sole cause.
            timeout <= rel_hold & ~rel_done & ~rel_drop;
          end else if (hcnt != '1) begin
            hcnt <= hcnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_dec_sel.sv
// Bench for rr_dec_sel with MAX_HOLD=4. It runs directed scenarios and then randomized traffic.
// The reference model works at the transaction level: who owns the bus, for how long, and who is next.
module tb_rr_dec_sel;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [1:0] sel;
  logic       en;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_en;
  bit m_to;
  int m_sel;
  int m_last;
  int m_len;

  rr_dec_sel #(.MAX_HOLD(MAXH), .HW(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .sel(sel), .en(en), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_en = 0; m_to = 0; m_sel = 0; m_last = 3; m_len = 0;
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic m_step();
    bit a, b, c;
    if (m_en) begin
      m_len++;
      a = done;
      b = !req[m_sel];
      c = (MAXH != 0) && (m_len >= MAXH);
      m_to = 0;
      if (a || b || c) begin
        m_en   = 0;
        m_last = m_sel;
        m_to   = c && !a && !b;
      end
    end else begin
      m_to = 0;
      if (req != 4'b0000) begin
        for (int i = 1; i <= 4; i++) begin
          if (req[(m_last + i) % 4]) begin
            m_sel = (m_last + i) % 4;
            break;
          end
        end
        m_en  = 1;
        m_len = 0;
      end
    end
  endtask

  // One clock: step the model, let the edge pass, then compare away from the edge.
  task automatic cycle();
    m_step();
    @(posedge clk);
    #1;
    chk("en", en, m_en);
    chk("sel", sel, m_sel);
    chk("timeout", timeout, m_to);
  endtask

  task automatic wait_en();
    int n = 0;
    while (en !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    chk("wait_en", en, 1);
  endtask

  task automatic go_idle();
    req = 4'b0000; done = 1'b0;
    repeat (3) cycle();
  endtask

  initial begin
    m_reset();
    // Reset state, observed while rst_n is still low
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", en, 0);
    chk("rst_sel", sel, 0);
    chk("rst_timeout", timeout, 0);
    rst_n = 1'b1;

    // Idle: no requests for 10 cycles
    repeat (10) cycle();
    chk("idle_en", en, 0);

    // All requesting, done on the 3rd grant cycle: expected order 0,1,2,3,0
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_en();
      chk("rr_order", sel, g % 4);
      done = 1'b0;
      repeat (2) cycle();
      done = 1'b1;
      cycle();
      chk("rr_release", en, 0);
      done = 1'b0;
    end
    go_idle();

    // Hold limit on channel 2: 4 grant cycles, then a timeout gap, then a re-grant
    req = 4'b0100;
    wait_en();
    chk("hold_sel", sel, 2);
    repeat (3) begin
      cycle();
      chk("hold_en", en, 1);
    end
    cycle();
    chk("hold_gap_en", en, 0);
    chk("hold_gap_to", timeout, 1);
    cycle();
    chk("hold_regrant", en, 1);
    chk("hold_regrant_sel", sel, 2);
    chk("hold_regrant_to", timeout, 0);
    go_idle();

    // done on the 4th cycle takes priority over the hold limit
    req = 4'b0100;
    wait_en();
    repeat (3) cycle();
    done = 1'b1;
    cycle();
    chk("done_wins_en", en, 0);
    chk("done_wins_to", timeout, 0);
    done = 1'b0;
    go_idle();

    // Channel 1 drops its request on the 2nd grant cycle while channel 3 rises
    req = 4'b0010;
    wait_en();
    chk("drop_sel1", sel, 1);
    cycle();
    req = 4'b1000;
    cycle();
    chk("drop_en", en, 0);
    cycle();
    chk("drop_next_sel", sel, 3);
    chk("drop_next_en", en, 1);
    go_idle();
    // last=3 here. Channel 1 wins, then releases. Channel 2 is then scanned before channel 3.
    req = 4'b0010;
    wait_en();
    chk("ptr_sel1", sel, 1);
    req = 4'b1100;
    cycle();
    chk("ptr_gap", en, 0);
    cycle();
    chk("ptr_sel2", sel, 2);
    go_idle();

    // Asynchronous reset in the middle of a grant on channel 2
    req = 4'b0100;
    wait_en();
    req = 4'b1111;
    cycle();
    chk("pre_rst_sel", sel, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_en", en, 0);
    chk("async_rst_to", timeout, 0);
    m_reset();
    #1 rst_n = 1'b1;
    cycle();
    chk("post_rst_sel", sel, 0);
    chk("post_rst_en", en, 1);

    // Randomized traffic. req changes only sometimes, so long grants still reach the hold limit.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) < 3) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
